// File: rtl/matrix_3x3_8bit.sv
// matrix_3x3_8bit: sliding 3x3 window generator for an 8-bit raster pixel stream.
// Two line memories hold the previous two rows; a 3x3 register window is presented
// two cycles after each accepted pixel, together with 2-cycle delayed sync signals.
// Optional feature macro: MATRIX_EDGE_REPLICATE_EN -- missing rows/columns at the top
// and left borders replicate the nearest valid pixel instead of reading as zero.
module matrix_3x3_8bit #(
   parameter int unsigned IMG_HDISP  = 1280,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned ROW_WIDTH  = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_y,
   output logic       matrix_frame_vsync,
   output logic       matrix_frame_href,
   output logic       matrix_frame_clken,
   output logic [7:0] matrix_p11,
   output logic [7:0] matrix_p12,
   output logic [7:0] matrix_p13,
   output logic [7:0] matrix_p21,
   output logic [7:0] matrix_p22,
   output logic [7:0] matrix_p23,
   output logic [7:0] matrix_p31,
   output logic [7:0] matrix_p32,
   output logic [7:0] matrix_p33,
   output logic       line_err
);

   // col_cnt has one extra bit so it can hold IMG_HDISP itself (overlong detect).
   localparam logic [ADDR_WIDTH:0] HDispC = (ADDR_WIDTH+1)'(IMG_HDISP);

   typedef enum logic [1:0] {StWaitFrame, StGap, StLine} state_e;

   state_e                state_q, state_d;
   logic [ROW_WIDTH-1:0]  row_q, row_d, row_eff;
   logic [ADDR_WIDTH:0]   col_q, col_d, col_eff;
   logic                  err_q, err_d;
   logic                  vsync_q1, vsync_q2, href_q1, href_q2;
   logic                  vsync_rise, vsync_fall, href_fall, pix_in;
   logic                  accept, wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [1:0]            row_sel, col_sel;

   logic [7:0]            mem_a [IMG_HDISP];
   logic [7:0]            mem_b [IMG_HDISP];

   // Stage 1: accepted pixel, memory read data and border position.
   logic                  s1_valid_q;
   logic [7:0]            s1_y_q, rd_a_q, rd_b_q;
   logic [1:0]            s1_row_q, s1_col_q;

   // Stage 2: window, win_q[row][col]; row 0 is two lines up, col 2 is newest.
   logic [2:0][2:0][7:0]  win_q, win_d;
   logic [2:0][7:0]       new_col;
   logic [7:0]            new_r1, new_r2, new_r3;
   logic                  clken_q;

   assign vsync_rise = per_frame_vsync & ~vsync_q1;
   assign vsync_fall = ~per_frame_vsync & vsync_q1;
   assign href_fall  = ~per_frame_href & href_q1;
   assign pix_in     = per_frame_href & per_frame_clken;
   assign wr_addr    = col_eff[ADDR_WIDTH-1:0];

   // Frame/line tracking; a vsync rise clears the counters before the same-cycle pixel.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = err_q;
      row_eff = row_q;
      col_eff = col_q;
      accept  = 1'b0;
      wr_en   = 1'b0;
      if (vsync_fall) begin
         state_d = StWaitFrame;
      end else begin
         case (state_q)
            StWaitFrame: begin
               if (vsync_rise) begin
                  row_d   = '0;
                  col_d   = '0;
                  err_d   = 1'b0;
                  row_eff = '0;
                  col_eff = '0;
                  state_d = StGap;
                  if (pix_in) begin
                     accept  = 1'b1;
                     state_d = StLine;
                  end
               end
            end
            StGap: begin
               if (pix_in) begin
                  accept  = 1'b1;
                  state_d = StLine;
               end
            end
            StLine: begin
               if (href_fall) begin
                  if (row_q != '1) row_d = row_q + ROW_WIDTH'(1);
                  col_d   = '0;
                  state_d = StGap;
               end else if (pix_in) begin
                  accept = 1'b1;
               end
            end
            default: state_d = StWaitFrame;
         endcase
      end
      if (accept) begin
         if (col_eff == HDispC) begin
            err_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            col_d = col_eff + (ADDR_WIDTH+1)'(1);
         end
      end
   end

   // Border position of the accepted pixel: 0, 1, or "2 or more".
   always_comb begin
      row_sel = 2'd2;
      col_sel = 2'd2;
      if (row_eff == '0) row_sel = 2'd0;
      else if (row_eff == ROW_WIDTH'(1)) row_sel = 2'd1;
      if (col_eff == '0) col_sel = 2'd0;
      else if (col_eff == (ADDR_WIDTH+1)'(1)) col_sel = 2'd1;
   end

   // Control state, counters, sync delay line and stage-1 pipeline register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StWaitFrame;
         row_q      <= '0;
         col_q      <= '0;
         err_q      <= 1'b0;
         vsync_q1   <= 1'b0;
         vsync_q2   <= 1'b0;
         href_q1    <= 1'b0;
         href_q2    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_y_q     <= '0;
         s1_row_q   <= '0;
         s1_col_q   <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         err_q      <= err_d;
         vsync_q1   <= per_frame_vsync;
         vsync_q2   <= vsync_q1;
         href_q1    <= per_frame_href;
         href_q2    <= href_q1;
         s1_valid_q <= wr_en;
         if (wr_en) begin
            s1_y_q   <= per_img_y;
            s1_row_q <= row_sel;
            s1_col_q <= col_sel;
         end
      end
   end

   // Line memories: read old contents, then push the column down one line.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         rd_a_q         <= mem_a[wr_addr];
         rd_b_q         <= mem_b[wr_addr];
         mem_a[wr_addr] <= per_img_y;
         mem_b[wr_addr] <= mem_a[wr_addr];
      end
   end

   // New column entering the window, with missing top rows filled.
   always_comb begin
      new_r3 = s1_y_q;
`ifdef MATRIX_EDGE_REPLICATE_EN
      new_r2 = (s1_row_q == 2'd0) ? s1_y_q : rd_a_q;
      new_r1 = (s1_row_q == 2'd2) ? rd_b_q : new_r2;
`else
      new_r2 = (s1_row_q == 2'd0) ? 8'h00 : rd_a_q;
      new_r1 = (s1_row_q == 2'd2) ? rd_b_q : 8'h00;
`endif
   end

   assign new_col = {new_r3, new_r2, new_r1};

   // Shift each row left by one, filling the left border at line start.
   always_comb begin
      win_d = win_q;
      for (int r = 0; r < 3; r++) begin
         win_d[r][2] = new_col[r];
         case (s1_col_q)
            2'd0: begin
`ifdef MATRIX_EDGE_REPLICATE_EN
               win_d[r][1] = new_col[r];
               win_d[r][0] = new_col[r];
`else
               win_d[r][1] = 8'h00;
               win_d[r][0] = 8'h00;
`endif
            end
            2'd1: begin
               win_d[r][1] = win_q[r][2];
`ifdef MATRIX_EDGE_REPLICATE_EN
               win_d[r][0] = win_q[r][2];
`else
               win_d[r][0] = 8'h00;
`endif
            end
            default: begin
               win_d[r][1] = win_q[r][2];
               win_d[r][0] = win_q[r][1];
            end
         endcase
      end
   end

   // Stage 2: registered window and its valid strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_q   <= '0;
         clken_q <= 1'b0;
      end else begin
         clken_q <= s1_valid_q;
         if (s1_valid_q) win_q <= win_d;
      end
   end

   assign matrix_frame_vsync = vsync_q2;
   assign matrix_frame_href  = href_q2;
   assign matrix_frame_clken = clken_q;
   assign line_err           = err_q;
   assign matrix_p11         = win_q[0][0];
   assign matrix_p12         = win_q[0][1];
   assign matrix_p13         = win_q[0][2];
   assign matrix_p21         = win_q[1][0];
   assign matrix_p22         = win_q[1][1];
   assign matrix_p23         = win_q[1][2];
   assign matrix_p31         = win_q[2][0];
   assign matrix_p32         = win_q[2][1];
   assign matrix_p33         = win_q[2][2];

endmodule

// File: tb/tb_matrix_3x3_8bit.sv
// tb_matrix_3x3_8bit: bench for matrix_3x3_8bit with IMG_HDISP=4. Expected windows come
// from an image array indexed by (row, col) and the border rules; honours
// MATRIX_EDGE_REPLICATE_EN the same way as the design.
module tb_matrix_3x3_8bit;

   localparam int unsigned HDISP = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned RW    = 11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
   logic [7:0] y = 8'h00;
   logic       o_vsync, o_href, o_clken, o_err;
   logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic [8:0][7:0] dut_win;

   matrix_3x3_8bit #(.IMG_HDISP(HDISP), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
      .per_img_y(y),
      .matrix_frame_vsync(o_vsync), .matrix_frame_href(o_href),
      .matrix_frame_clken(o_clken),
      .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
      .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
      .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
      .line_err(o_err)
   );

   always #5 clk = ~clk;

   // [0] = p11 ... [8] = p33
   assign dut_win = {p33, p32, p31, p23, p22, p21, p13, p12, p11};

   typedef struct packed {
      logic            rst;
      logic            clken;
      logic            vsync;
      logic            href;
      logic            err;
      logic            tchk;
      logic [8:0][7:0] win;
      logic [8:0][7:0] twin;
   } exp_t;

   typedef struct packed {
      logic [7:0]      y;
      logic            chk;
      logic [8:0][7:0] win;
   } vec_t;

   exp_t pipe0, pipe1, pipe2;
   vec_t tbl [12];

   int n_tests = 0, n_fail = 0, n_strobe = 0;

   // Reference model: the image as received plus frame position.
   logic [7:0] img [16][4];
   int  m_row, m_col;
   bit  m_err, m_in, m_line, m_prev_vs, m_prev_hs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0][7:0] mk(input logic [7:0] a11, a12, a13, a21, a22, a23,
                                          a31, a32, a33);
      return {a33, a32, a31, a23, a22, a21, a13, a12, a11};
   endfunction

   function automatic logic [7:0] get_pix(input int rr, input int cc);
`ifdef MATRIX_EDGE_REPLICATE_EN
      if (rr < 0) rr = 0;
      if (cc < 0) cc = 0;
`else
      if (rr < 0 || cc < 0) return 8'h00;
`endif
      return img[rr][cc];
   endfunction

   task automatic clk_step();
      @(posedge clk);
      if (pipe0.rst) begin
         pipe2 = pipe0;
         pipe1 = pipe0;
      end else begin
         pipe2 = pipe1;
         pipe1 = pipe0;
      end
      @(negedge clk);
      if (o_clken) n_strobe++;
      check("clken_out", o_clken, pipe2.clken);
      check("vsync_out", o_vsync, pipe2.vsync);
      check("href_out", o_href, pipe2.href);
      check("line_err", o_err, pipe1.err);
      if (pipe2.clken || pipe2.rst)
         for (int k = 0; k < 9; k++)
            check($sformatf("win_p%0d%0d", k / 3 + 1, k % 3 + 1), dut_win[k], pipe2.win[k]);
      if (pipe2.tchk)
         for (int k = 0; k < 9; k++)
            check($sformatf("table_p%0d%0d", k / 3 + 1, k % 3 + 1), dut_win[k], pipe2.twin[k]);
   endtask

   task automatic drive(input bit rst, input bit vs, input bit hs, input bit ck,
                        input logic [7:0] yy, input bit tchk = 1'b0,
                        input logic [8:0][7:0] twin = '0);
      exp_t e;
      e       = '0;
      rst_n   = ~rst;
      vsync   = vs;
      href    = hs;
      clken   = ck;
      y       = yy;
      e.vsync = vs;
      e.href  = hs;
      if (rst) begin
         m_row = 0; m_col = 0; m_err = 0; m_in = 0; m_line = 0;
         m_prev_vs = 0; m_prev_hs = 0;
         e.rst = 1'b1; e.vsync = 1'b0; e.href = 1'b0;
      end else begin
         if (vs && !m_prev_vs) begin
            m_row = 0; m_col = 0; m_err = 0; m_in = 1; m_line = 0;
         end
         if (!vs && m_prev_vs) m_in = 0;
         if (m_in && !hs && m_prev_hs && m_line) begin
            m_row++; m_col = 0; m_line = 0;
         end
         if (m_in && hs && ck) begin
            m_line = 1;
            if (m_col >= int'(HDISP)) begin
               m_err = 1;
            end else begin
               img[m_row][m_col] = yy;
               e.clken = 1'b1;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     e.win[i*3+j] = get_pix(m_row - 2 + i, m_col - 2 + j);
               m_col++;
            end
         end
         m_prev_vs = vs;
         m_prev_hs = hs;
      end
      e.err  = m_err;
      e.tchk = tchk;
      e.twin = twin;
      pipe0  = e;
      clk_step();
   endtask

   // href low; clken noise must be ignored.
   task automatic idle(input int n, input bit vs);
      for (int i = 0; i < n; i++) drive(1'b0, vs, 1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
   endtask

   // mode 0: continuous clken, 1: clken 1,0,1,0, 2: random stalls.
   task automatic send_line(input int len, input int mode, input int tag, input bit rnd,
                            input bit first_at_rise);
      int stall;
      for (int c = 0; c < len; c++) begin
         stall = (mode == 2) ? int'($urandom_range(2, 0)) : 0;
         if (c == 0 && first_at_rise) stall = 0;
         for (int s = 0; s < stall; s++) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
         drive(1'b0, 1'b1, 1'b1, 1'b1, rnd ? 8'($urandom) : 8'(16 * tag + c));
         if (mode == 1) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
      end
      idle(1 + int'($urandom_range(2, 0)), 1'b1);
   endtask

   task automatic send_frame(input int rows, input int len, input int mode, input bit rnd,
                             input bit coincide);
      if (!coincide) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int r = 0; r < rows; r++) send_line(len, mode, r, rnd, coincide && r == 0);
      idle(3, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int s0;
      pipe0 = '0; pipe0.rst = 1'b1;
      pipe1 = pipe0; pipe2 = pipe0;

      // Directed 3x4 frame, pixel = 16*row + col, with hand-computed windows.
      for (int k = 0; k < 12; k++) begin
         tbl[k].y   = 8'(16 * (k / 4) + k % 4);
         tbl[k].chk = 1'b0;
         tbl[k].win = '0;
      end
      tbl[11].chk = 1'b1;
      tbl[11].win = mk(8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23);
      tbl[2].chk = 1'b1;
      tbl[5].chk = 1'b1;
      tbl[8].chk = 1'b1;
`ifdef MATRIX_EDGE_REPLICATE_EN
      tbl[2].win = mk(8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02);
      tbl[5].win = mk(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11);
      tbl[8].win = mk(8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20);
`else
      tbl[2].win = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02);
      tbl[5].win = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11);
      tbl[8].win = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20);
`endif

      // Reset with all inputs low.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("reset_line_err", o_err, 0);
      check("reset_p33", p33, 0);
      idle(2, 1'b0);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, tbl[r*4+c].y, tbl[r*4+c].chk, tbl[r*4+c].win);
         idle(2, 1'b1);
      end
      idle(3, 1'b0);

      // Same frame with clken toggling.
      send_frame(3, 4, 1, 1'b0, 1'b0);

      // Single pixel 0x05 arriving in the vsync-rise cycle: column 0 of row 0.
`ifdef MATRIX_EDGE_REPLICATE_EN
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1,
            mk(8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05));
`else
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1,
            mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05));
`endif
      idle(2, 1'b1);
      idle(3, 1'b0);

      // Overlong line: 5 pixels -> 4 strobes and a sticky error.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      s0 = n_strobe;
      send_line(5, 0, 5, 1'b0, 1'b0);
      idle(1, 1'b1);
      check("overlong_strobes", n_strobe - s0, 4);
      check("line_err_set", o_err, 1);
      idle(3, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("line_err_clear", o_err, 0);
      send_line(4, 0, 6, 1'b0, 1'b0);
      idle(3, 1'b0);

      // Reset asserted at row 1, col 2.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      send_line(4, 0, 3, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h41);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h43);
      check("midreset_clken", o_clken, 0);
      check("midreset_vsync", o_vsync, 0);
      check("midreset_href", o_href, 0);
      check("midreset_p33", p33, 0);
      check("midreset_p32", p32, 0);
      idle(3, 1'b0);
      send_frame(2, 4, 0, 1'b0, 1'b0);

      // Randomised frames.
      for (int f = 0; f < 12; f++)
         send_frame(1 + int'($urandom_range(4, 0)), 1 + int'($urandom_range(4, 0)),
                    int'($urandom_range(2, 0)), 1'b1, 1'($urandom_range(1, 0)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
